// File: rtl/sipo_rx_if.sv
// sipo_rx_if: serial-in / word-out bundle between a bit source (master) and sipo_rx (slave).
interface sipo_rx_if #(parameter int SIZE = 8);
  logic            data_in;
  logic            enable_in;
  logic            ready_in;
  logic [SIZE-1:0] data_out;
  logic            valid_out;
  logic            busy_out;
  logic            overrun_out;
  modport master (output data_in, enable_in, ready_in, input data_out, valid_out, busy_out, overrun_out);
  modport slave  (input data_in, enable_in, ready_in, output data_out, valid_out, busy_out, overrun_out);
endinterface

// File: rtl/sipo_rx.sv
// sipo_rx: serial-to-parallel receiver with valid/ready word output and sticky overrun.
// Define SIPO_RX_LSB_FIRST_EN for LSB-first bit order (default MSB-first).
module sipo_rx #(
  parameter int SIZE = 8
) (
  input logic   clk_in,
  input logic   reset_in,
  sipo_rx_if.slave bus
);
  localparam int CW = $clog2(SIZE);
  localparam logic [0:0] IDLE = 1'b0, SHIFT = 1'b1;
  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-2:0] shift_q, shift_d;
  logic [SIZE-1:0] data_q, data_d, word;
  logic            valid_q, valid_d, busy_q, ovr_q, ovr_d, last, load;
`ifdef SIPO_RX_LSB_FIRST_EN
  assign word    = {bus.data_in, shift_q};
  assign shift_d = bus.enable_in ? word[SIZE-1:1] : shift_q;
`else
  assign word    = {shift_q, bus.data_in};
  assign shift_d = bus.enable_in ? word[SIZE-2:0] : shift_q;
`endif
  // a completed word is dropped only when the previous one is still held and not taken now
  always_comb begin
    last    = bus.enable_in && state_q == SHIFT && cnt_q == CW'(SIZE - 1);
    load    = last && (!valid_q || bus.ready_in);
    state_d = bus.enable_in ? SHIFT : IDLE;
    cnt_d   = (!bus.enable_in || last) ? '0 : cnt_q + 1'b1;
    data_d  = load ? word : data_q;
    valid_d = load || (valid_q && !bus.ready_in);
    ovr_d   = ovr_q || (last && valid_q && !bus.ready_in);
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= cnt_d != '0;
      ovr_q   <= ovr_d;
    end
  end
  assign bus.data_out    = data_q;
  assign bus.valid_out   = valid_q;
  assign bus.busy_out    = busy_q;
  assign bus.overrun_out = ovr_q;
endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: directed stimulus with a scoreboard queue popped by a monitor on every accepted word.
module tb_sipo_rx;
  localparam int SIZE = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [SIZE-1:0] exp_q[$];
  sipo_rx_if #(.SIZE(SIZE)) bus ();
  sipo_rx #(.SIZE(SIZE)) dut (.clk_in(clk), .reset_in(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_word(input logic [SIZE-1:0] w, input logic rdy, input logic rdy_last);
    for (int i = 0; i < SIZE; i++) begin
      bus.enable_in = 1'b1;
`ifdef SIPO_RX_LSB_FIRST_EN
      bus.data_in = w[i];
`else
      bus.data_in = w[SIZE-1-i];
`endif
      bus.ready_in = (i == SIZE - 1) ? rdy_last : rdy;
      tick();
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.valid_out && bus.ready_in) begin
      if (exp_q.size() == 0) chk("unexpected_word", {24'h0, bus.data_out}, 32'hdead);
      else chk("word", {24'h0, bus.data_out}, {24'h0, exp_q.pop_front()});
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.data_in = 1'b0;
    bus.enable_in = 1'b0;
    bus.ready_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_busy", {31'h0, bus.busy_out}, 32'h0);
    end
    chk("rst_data", {24'h0, bus.data_out}, 32'h0);
    chk("rst_valid", {31'h0, bus.valid_out}, 32'h0);
    chk("rst_ovr", {31'h0, bus.overrun_out}, 32'h0);
    // single word held until consumed
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 1'b0, 1'b0);
    bus.enable_in = 1'b0;
    chk("a5_valid", {31'h0, bus.valid_out}, 32'h1);
    chk("a5_data", {24'h0, bus.data_out}, 32'hA5);
    chk("a5_busy", {31'h0, bus.busy_out}, 32'h0);
    tick();
    tick();
    chk("a5_hold_valid", {31'h0, bus.valid_out}, 32'h1);
    chk("a5_hold_data", {24'h0, bus.data_out}, 32'hA5);
    bus.ready_in = 1'b1;
    tick();
    bus.ready_in = 1'b0;
    chk("a5_taken", {31'h0, bus.valid_out}, 32'h0);
    // back-to-back words, ready held high
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_word(8'h3C, 1'b1, 1'b1);
    chk("3c_valid", {31'h0, bus.valid_out}, 32'h1);
    chk("3c_data", {24'h0, bus.data_out}, 32'h3C);
    send_word(8'hC3, 1'b1, 1'b1);
    chk("c3_valid", {31'h0, bus.valid_out}, 32'h1);
    chk("c3_data", {24'h0, bus.data_out}, 32'hC3);
    bus.enable_in = 1'b0;
    tick();
    bus.ready_in = 1'b0;
    chk("b2b_valid_clr", {31'h0, bus.valid_out}, 32'h0);
    chk("b2b_ovr", {31'h0, bus.overrun_out}, 32'h0);
    // overrun: second word dropped, flag sticky
    exp_q.push_back(8'h11);
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    bus.enable_in = 1'b0;
    chk("ovr_data", {24'h0, bus.data_out}, 32'h11);
    chk("ovr_flag", {31'h0, bus.overrun_out}, 32'h1);
    bus.ready_in = 1'b1;
    tick();
    bus.ready_in = 1'b0;
    tick();
    chk("ovr_sticky", {31'h0, bus.overrun_out}, 32'h1);
    chk("ovr_valid_clr", {31'h0, bus.valid_out}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovr_rst", {31'h0, bus.overrun_out}, 32'h0);
    // abort after 5 bits
    for (int i = 0; i < 5; i++) begin
      bus.enable_in = 1'b1;
      bus.data_in = 1'b1;
      tick();
    end
    chk("abort_busy", {31'h0, bus.busy_out}, 32'h1);
    bus.enable_in = 1'b0;
    tick();
    chk("abort_busy_clr", {31'h0, bus.busy_out}, 32'h0);
    chk("abort_valid", {31'h0, bus.valid_out}, 32'h0);
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 1'b0, 1'b0);
    bus.enable_in = 1'b0;
    chk("5a_data", {24'h0, bus.data_out}, 32'h5A);
    chk("5a_ovr", {31'h0, bus.overrun_out}, 32'h0);
    bus.ready_in = 1'b1;
    tick();
    bus.ready_in = 1'b0;
    // completion and consumption on the same edge
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h7E);
    send_word(8'h81, 1'b0, 1'b0);
    send_word(8'h7E, 1'b0, 1'b1);
    bus.ready_in = 1'b0;
    bus.enable_in = 1'b0;
    chk("same_edge_valid", {31'h0, bus.valid_out}, 32'h1);
    chk("same_edge_data", {24'h0, bus.data_out}, 32'h7E);
    chk("same_edge_ovr", {31'h0, bus.overrun_out}, 32'h0);
    // reset mid-word clears pending word and partial bits
    for (int i = 0; i < 3; i++) begin
      bus.enable_in = 1'b1;
      bus.data_in = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.enable_in = 1'b0;
    void'(exp_q.pop_front());
    chk("midrst_valid", {31'h0, bus.valid_out}, 32'h0);
    chk("midrst_busy", {31'h0, bus.busy_out}, 32'h0);
    chk("midrst_data", {24'h0, bus.data_out}, 32'h0);
    tick();
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
